// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - data bus and SRAM port bundle for mem_bus_responder
// Optional read-parity signals exist only when MBR_RD_PARITY_EN is defined.
interface mem_bus_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              i_data_bus_enable;
    logic              i_data_bus_rw;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] o_rdata;
    logic              o_ack;
    logic              o_busy;
    logic              o_mem_ce;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
`ifdef MBR_RD_PARITY_EN
    logic              i_mem_rpar;
    logic              o_rd_err;
`endif

    // Responder side: samples bus requests and SRAM read data, drives everything else.
    modport slave (
`ifdef MBR_RD_PARITY_EN
        input  i_mem_rpar,
        output o_rd_err,
`endif
        input  i_data_bus_enable,
        input  i_data_bus_rw,
        input  i_addr,
        input  i_wdata,
        input  i_mem_rdata,
        output o_rdata,
        output o_ack,
        output o_busy,
        output o_mem_ce,
        output o_mem_we,
        output o_mem_addr,
        output o_mem_wdata
    );

    modport master (
`ifdef MBR_RD_PARITY_EN
        output i_mem_rpar,
        input  o_rd_err,
`endif
        output i_data_bus_enable,
        output i_data_bus_rw,
        output i_addr,
        output i_wdata,
        output i_mem_rdata,
        input  o_rdata,
        input  o_ack,
        input  o_busy,
        input  o_mem_ce,
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_wdata
    );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - data bus target driving a single-port synchronous SRAM
// Optional read parity check enabled by defining MBR_RD_PARITY_EN.
module mem_bus_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  clk_166M66,
    input  logic                  mcu_sys_rst_n,
    mem_bus_responder_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [2:0] RD_LAT_L = 3'(RD_LAT);

    state_t     state;
    logic [2:0] lat_cnt;
    logic       rw_q;

    // Every output is a register so the SRAM pins and bus strobes are glitch-free.
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            state           <= IDLE;
            lat_cnt         <= 3'd0;
            rw_q            <= 1'b0;
            bus.o_rdata     <= '0;
            bus.o_ack       <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_mem_ce    <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
`ifdef MBR_RD_PARITY_EN
            bus.o_rd_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.o_ack    <= 1'b0;
                    bus.o_mem_ce <= 1'b0;
                    bus.o_mem_we <= 1'b0;
                    if (bus.i_data_bus_enable) begin
                        rw_q            <= bus.i_data_bus_rw;
                        bus.o_mem_addr  <= bus.i_addr;
                        bus.o_mem_wdata <= bus.i_wdata;
                        bus.o_mem_ce    <= 1'b1;
                        bus.o_mem_we    <= bus.i_data_bus_rw;
                        bus.o_busy      <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.o_mem_ce <= 1'b0;
                    bus.o_mem_we <= 1'b0;
                    if (rw_q) begin
                        bus.o_ack <= 1'b1;
                        state     <= ACK;
                    end else begin
                        lat_cnt <= RD_LAT_L;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    // Count of 1 marks the cycle the SRAM presents the read word.
                    if (lat_cnt == 3'd1) begin
                        bus.o_rdata  <= bus.i_mem_rdata;
                        bus.o_ack    <= 1'b1;
`ifdef MBR_RD_PARITY_EN
                        bus.o_rd_err <= ^{bus.i_mem_rdata, bus.i_mem_rpar};
`endif
                        state        <= ACK;
                    end
                end
                ACK: begin
                    bus.o_ack    <= 1'b0;
                    bus.o_busy   <= 1'b0;
`ifdef MBR_RD_PARITY_EN
                    bus.o_rd_err <= 1'b0;
`endif
                    state        <= IDLE;
                end
                default: begin
                    bus.o_ack    <= 1'b0;
                    bus.o_busy   <= 1'b0;
                    bus.o_mem_ce <= 1'b0;
                    bus.o_mem_we <= 1'b0;
                    lat_cnt      <= 3'd0;
`ifdef MBR_RD_PARITY_EN
                    bus.o_rd_err <= 1'b0;
`endif
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - vector table plus scoreboard bench for mem_bus_responder
// Builds with or without MBR_RD_PARITY_EN.
module tb_mem_bus_responder;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mem_bus_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk_166M66    (clk),
        .mcu_sys_rst_n (rst_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: writes on the strobe edge, read word valid RD_LAT cycles after issue.
    logic [31:0] mem [256];
    logic [31:0] pd [RD_LAT];
    logic        pv [RD_LAT];
    logic        pp [RD_LAT];
    logic        flip_par = 1'b0;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (bus.o_mem_ce && bus.o_mem_we) mem[bus.o_mem_addr[7:0]] <= bus.o_mem_wdata;
        pd[0] <= mem[bus.o_mem_addr[7:0]];
        pp[0] <= (^mem[bus.o_mem_addr[7:0]]) ^ flip_par;
        pv[0] <= bus.o_mem_ce && !bus.o_mem_we;
        for (int i = 1; i < RD_LAT; i++) begin
            pd[i] <= pd[i-1];
            pp[i] <= pp[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign bus.i_mem_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : 32'hBADC0DE5;
`ifdef MBR_RD_PARITY_EN
    assign bus.i_mem_rpar = pv[RD_LAT-1] ? pp[RD_LAT-1] : 1'b1;
`endif

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        flip;
        logic        b2b;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    iss_t iss_q[$];
    ack_t ack_q[$];
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   ce_count = 0;
    int   ack_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Scoreboard monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        iss_t ie;
        ack_t ae;
        if (rst_n) begin
            if (bus.o_mem_ce) begin
                ce_count++;
                if (iss_q.size() == 0) fail_now("unexpected_mem_ce");
                else begin
                    ie = iss_q.pop_front();
                    chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
                    chk("mem_we", 64'(bus.o_mem_we), 64'(ie.we));
                    chk("mem_addr", 64'(bus.o_mem_addr), 64'(ie.addr));
                    chk("mem_wdata", 64'(bus.o_mem_wdata), 64'(ie.wdata));
                end
            end else if (bus.o_mem_we) begin
                fail_now("we_without_ce");
            end
            if (bus.o_ack) begin
                ack_count++;
                if (ack_q.size() == 0) fail_now("unexpected_ack");
                else begin
                    ae = ack_q.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(ae.cyc));
                    chk("ack_rdata", 64'(bus.o_rdata), 64'(ae.rdata));
`ifdef MBR_RD_PARITY_EN
                    chk("ack_rd_err", 64'(bus.o_rd_err), 64'(ae.err));
`endif
                end
            end
`ifdef MBR_RD_PARITY_EN
            else if (bus.o_rd_err) fail_now("rd_err_outside_ack");
`endif
            chk("busy", 64'(bus.o_busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Called just after a rising edge: the following edge samples the request.
    task automatic start_access(input logic rw, input logic [15:0] a, input logic [31:0] wd,
                                input logic fl, input logic [31:0] er, input logic ee);
        int ack_cyc;
        ack_cyc = rw ? cyc + 2 : cyc + 2 + RD_LAT;
        bus.i_data_bus_enable = 1'b1;
        bus.i_data_bus_rw     = rw;
        bus.i_addr            = a;
        bus.i_wdata           = wd;
        flip_par              = fl;
        iss_q.push_back('{rw, a, wd, cyc + 1});
        ack_q.push_back('{ack_cyc, er, rw ? 1'b0 : ee});
        busy_lo = cyc + 1;
        busy_hi = ack_cyc;
    endtask

    task automatic wait_ack(input int target);
        int n;
        n = 0;
        while (ack_count < target && n < 64) begin
            @(posedge clk);
            n++;
        end
        if (ack_count < target) fail_now("ack_timeout");
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdata"}, 64'(bus.o_rdata), 64'h0);
        chk({tag, "_ack"}, 64'(bus.o_ack), 64'h0);
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'h0);
        chk({tag, "_ce"}, 64'(bus.o_mem_ce), 64'h0);
        chk({tag, "_we"}, 64'(bus.o_mem_we), 64'h0);
        chk({tag, "_maddr"}, 64'(bus.o_mem_addr), 64'h0);
        chk({tag, "_mwdata"}, 64'(bus.o_mem_wdata), 64'h0);
`ifdef MBR_RD_PARITY_EN
        chk({tag, "_rd_err"}, 64'(bus.o_rd_err), 64'h0);
`endif
    endtask

    vec_t vecs[10];

    initial begin
        int expected_acks;
        int ce_before;
        int ack_before;
        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 32'h00000000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0020, 32'h00000001, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 16'h0021, 32'h00000003, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b0, 16'h0020, 32'h11111111, 1'b0, 1'b0, 32'h00000001, 1'b0};
        vecs[5] = '{1'b0, 16'h0021, 32'h22222222, 1'b0, 1'b1, 32'h00000003, 1'b0};
        vecs[6] = '{1'b1, 16'hFFFF, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h00000003, 1'b0};
        vecs[7] = '{1'b0, 16'hFFFF, 32'h00000000, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0};
        vecs[8] = '{1'b0, 16'h0020, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b1};
        vecs[9] = '{1'b0, 16'h0010, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};

        bus.i_data_bus_enable = 1'b0;
        bus.i_data_bus_rw     = 1'b0;
        bus.i_addr            = '0;
        bus.i_wdata           = '0;
        expected_acks         = 0;

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 check_all_zero("post_reset");

        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].b2b) begin
                bus.i_data_bus_enable = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            start_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].flip,
                         vecs[i].exp_rdata, vecs[i].exp_err);
            expected_acks++;
            wait_ack(expected_acks);
        end

        // Enable dropped and request fields changed in the issue cycle of a read.
        bus.i_data_bus_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 start_access(1'b0, 16'h0021, 32'h0, 1'b0, 32'h00000003, 1'b0);
        expected_acks++;
        @(posedge clk);
        #1;
        bus.i_data_bus_enable = 1'b0;
        bus.i_data_bus_rw     = 1'b1;
        bus.i_addr            = 16'h0099;
        bus.i_wdata           = 32'h12345678;
        wait_ack(expected_acks);
        chk("drop_hold_maddr", 64'(bus.o_mem_addr), 64'h0021);
        chk("drop_hold_rdata", 64'(bus.o_rdata), 64'h00000003);

        // Reset while waiting on read data.
        repeat (2) @(posedge clk);
        #1 start_access(1'b0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        bus.i_data_bus_enable = 1'b0;
        rst_n = 1'b0;
        #1 check_all_zero("mid_read_reset");
        iss_q.delete();
        ack_q.delete();
        busy_lo = 1;
        busy_hi = 0;
        ce_before  = ce_count;
        ack_before = ack_count;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("reset_no_ack", 64'(ack_count), 64'(ack_before));
        chk("reset_no_ce", 64'(ce_count), 64'(ce_before));
        expected_acks = ack_count;

        // Recovery after reset.
        start_access(1'b0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        expected_acks++;
        wait_ack(expected_acks);
        bus.i_data_bus_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(iss_q.size() + ack_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
